// File: rtl/display_scan_ctrl.sv
// Frame-read scan sequencer for the display DataPath: generates active/blank timing,
// the frame read index and ping-pong buffer selection/release.
module display_scan_ctrl #(
    parameter int CNT_W  = 10,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CSDisplay,
    input  logic [CNT_W-1:0]  HBOut_PD,
    input  logic [CNT_W-1:0]  VBOut_PD,
    input  logic [CNT_W-1:0]  AIPOut_PD,
    input  logic [CNT_W-1:0]  AILOut_PD,
    input  logic              Buf0Empty,
    input  logic              Buf1Empty,
    output logic              readFrame,
    output logic [ADDR_W-1:0] FrameRInd,
    output logic              BufSel,
    output logic [1:0]        BufRelease,
    output logic              HBlank,
    output logic              VBlank,
    output logic              FrameStart,
    output logic              Underrun,
    output logic              CfgErr
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WAIT_BUF = 3'd1;
    localparam logic [2:0] ACTIVE   = 3'd2;
    localparam logic [2:0] HBLK     = 3'd3;
    localparam logic [2:0] VBLK     = 3'd4;

    localparam int PROD_W = (2 * CNT_W > ADDR_W + 1) ? 2 * CNT_W : ADDR_W + 1;
    localparam logic [PROD_W-1:0] MAX_PIXELS = PROD_W'(1) << ADDR_W;
    localparam logic [CNT_W-1:0]  ONE        = CNT_W'(1);
    localparam logic [CNT_W:0]    ONE_X      = (CNT_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ONE_A      = ADDR_W'(1);

    logic [2:0]        state;
    logic [CNT_W-1:0]  hb_q, vb_q, aip_q, ail_q;
    logic [CNT_W-1:0]  pix_cnt, line_cnt, vline_cnt;
    logic [CNT_W:0]    blk_cnt;
    logic [ADDR_W-1:0] idx;
    logic              buf_sel;
    logic [1:0]        buf_release;
    logic              underrun;
    logic              cfg_err;

    logic [PROD_W-1:0] pixel_count;
    logic [CNT_W:0]    vline_len;
    logic              cfg_in_ok;
    logic              last_pix, last_line, last_vline, hb_done, last_vclk;
    logic              line_end, frame_end, other_empty;

    // Legality is judged on the live inputs, since that is what gets latched this clock.
    always_comb begin
        pixel_count = PROD_W'(AIPOut_PD) * PROD_W'(AILOut_PD);
        cfg_in_ok   = (AIPOut_PD != '0) && (AILOut_PD != '0) && (pixel_count <= MAX_PIXELS);
        vline_len   = {1'b0, aip_q} + {1'b0, hb_q};
        last_pix    = (pix_cnt == aip_q - ONE);
        last_line   = (line_cnt == ail_q - ONE);
        last_vline  = (vline_cnt == vb_q - ONE);
        hb_done     = (blk_cnt == {1'b0, hb_q} - ONE_X);
        last_vclk   = (blk_cnt == vline_len - ONE_X);
        line_end    = ((state == ACTIVE) && last_pix && (hb_q == '0)) ||
                      ((state == HBLK) && hb_done);
        frame_end   = (line_end && last_line && (vb_q == '0)) ||
                      ((state == VBLK) && last_vclk && last_vline);
        other_empty = buf_sel ? Buf0Empty : Buf1Empty;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            hb_q        <= '0;
            vb_q        <= '0;
            aip_q       <= '0;
            ail_q       <= '0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            vline_cnt   <= '0;
            blk_cnt     <= '0;
            idx         <= '0;
            buf_sel     <= 1'b0;
            buf_release <= 2'b00;
            underrun    <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            buf_release <= 2'b00;
            case (state)
                IDLE: begin
                    if (CSDisplay) begin
                        hb_q    <= HBOut_PD;
                        vb_q    <= VBOut_PD;
                        aip_q   <= AIPOut_PD;
                        ail_q   <= AILOut_PD;
                        cfg_err <= !cfg_in_ok;
                        if (cfg_in_ok) state <= WAIT_BUF;
                    end
                end
                WAIT_BUF: begin
                    if (!CSDisplay) begin
                        state <= IDLE;
                    end else if (!Buf0Empty || !Buf1Empty) begin
                        buf_sel  <= Buf0Empty;
                        pix_cnt  <= '0;
                        line_cnt <= '0;
                        idx      <= '0;
                        state    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    idx     <= idx + ONE_A;
                    pix_cnt <= pix_cnt + ONE;
                    if (last_pix && (hb_q != '0)) begin
                        blk_cnt <= '0;
                        state   <= HBLK;
                    end
                end
                HBLK: blk_cnt <= blk_cnt + ONE_X;
                VBLK: begin
                    if (last_vclk) begin
                        blk_cnt   <= '0;
                        vline_cnt <= vline_cnt + ONE;
                    end else begin
                        blk_cnt <= blk_cnt + ONE_X;
                    end
                end
                default: state <= IDLE;
            endcase

            // NOTE: the line/frame handling below deliberately overrides the per-state
            // assignments above; with non-blocking updates the last assignment wins.
            if (line_end && !frame_end) begin
                pix_cnt <= '0;
                if (last_line) begin
                    blk_cnt   <= '0;
                    vline_cnt <= '0;
                    state     <= VBLK;
                end else begin
                    line_cnt <= line_cnt + ONE;
                    state    <= ACTIVE;
                end
            end

            if (frame_end) begin
                pix_cnt  <= '0;
                line_cnt <= '0;
                idx      <= '0;
                if (CSDisplay) begin
                    hb_q  <= HBOut_PD;
                    vb_q  <= VBOut_PD;
                    aip_q <= AIPOut_PD;
                    ail_q <= AILOut_PD;
                end
                if (!CSDisplay) begin
                    buf_release[buf_sel] <= 1'b1;
                    buf_sel              <= 1'b0;
                    state                <= IDLE;
                end else if (!cfg_in_ok) begin
                    buf_release[buf_sel] <= 1'b1;
                    buf_sel              <= 1'b0;
                    cfg_err              <= 1'b1;
                    state                <= IDLE;
                end else if (!other_empty) begin
                    buf_release[buf_sel] <= 1'b1;
                    buf_sel              <= !buf_sel;
                    state                <= ACTIVE;
                end else begin
                    underrun <= 1'b1;
                    state    <= ACTIVE;
                end
            end
        end
    end

    // Outputs decode registered state only, so reset clears them without waiting for a clock.
    assign readFrame  = (state == ACTIVE);
    assign FrameRInd  = idx;
    assign BufSel     = buf_sel;
    assign BufRelease = buf_release;
    assign HBlank     = (state == HBLK) || ((state == VBLK) && (blk_cnt >= {1'b0, aip_q}));
    assign VBlank     = (state == VBLK);
    assign FrameStart = (state == ACTIVE) && (pix_cnt == '0) && (line_cnt == '0);
    assign Underrun   = underrun;
    assign CfgErr     = cfg_err;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: directed frames push expected pixels and
// release pulses; negedge monitors pop and compare whenever the DUT presents them.
module tb_display_scan_ctrl;

    localparam int CNT_W  = 10;
    localparam int ADDR_W = 16;

    logic              clk;
    logic              reset;
    logic              CSDisplay;
    logic [CNT_W-1:0]  HBOut_PD, VBOut_PD, AIPOut_PD, AILOut_PD;
    logic              Buf0Empty, Buf1Empty;
    logic              readFrame;
    logic [ADDR_W-1:0] FrameRInd;
    logic              BufSel;
    logic [1:0]        BufRelease;
    logic              HBlank, VBlank, FrameStart, Underrun, CfgErr;

    display_scan_ctrl #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .CSDisplay  (CSDisplay),
        .HBOut_PD   (HBOut_PD),
        .VBOut_PD   (VBOut_PD),
        .AIPOut_PD  (AIPOut_PD),
        .AILOut_PD  (AILOut_PD),
        .Buf0Empty  (Buf0Empty),
        .Buf1Empty  (Buf1Empty),
        .readFrame  (readFrame),
        .FrameRInd  (FrameRInd),
        .BufSel     (BufSel),
        .BufRelease (BufRelease),
        .HBlank     (HBlank),
        .VBlank     (VBlank),
        .FrameStart (FrameStart),
        .Underrun   (Underrun),
        .CfgErr     (CfgErr)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic              sel;
        logic              fs;
    } pix_t;

    pix_t       pix_q[$];
    logic [1:0] rel_q[$];
    int         errors = 0;
    int         checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({readFrame, FrameRInd, BufSel, BufRelease, HBlank, VBlank,
                    FrameStart, Underrun, CfgErr});
    endfunction

    // Pixel monitor
    always @(negedge clk) begin : pix_mon
        pix_t e;
        if (readFrame === 1'b1) begin
            if (pix_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pixel: got index %0d sel %0d, expected no active pixel",
                         FrameRInd, BufSel);
            end else begin
                e = pix_q.pop_front();
                check("pixel", 32'({FrameRInd, BufSel, FrameStart}), 32'(e));
            end
        end
    end

    // Release monitor
    always @(negedge clk) begin : rel_mon
        logic [1:0] r;
        if (BufRelease !== 2'b00) begin
            if (rel_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_release: got %b, expected no pulse", BufRelease);
            end else begin
                r = rel_q.pop_front();
                check("buf_release", 32'(BufRelease), 32'(r));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_point();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic sel, input int n);
        for (int i = 0; i < n; i++)
            pix_q.push_back('{idx: ADDR_W'(i), sel: sel, fs: 1'(i == 0)});
    endtask

    task automatic wait_fs(input string name);
        bit ok = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (FrameStart === 1'b1) begin
                ok = 1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_rel(input string name);
        bit ok = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (BufRelease !== 2'b00) begin
                ok = 1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    // Called at the negedge of a FrameStart; counts one full frame period.
    task automatic measure_frame();
        int cyc = 1;
        int rd  = int'(readFrame);
        int hb  = int'(HBlank);
        int vb  = int'(VBlank);
        bit ok  = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (FrameStart === 1'b1) begin
                ok = 1;
                break;
            end
            cyc++;
            rd += int'(readFrame);
            hb += int'(HBlank);
            vb += int'(VBlank);
        end
        check("next_frame_start", 32'(ok), 32'd1);
        check("frame_period", 32'(cyc), 32'd24);
        check("read_clocks", 32'(rd), 32'd12);
        check("hblank_clocks", 32'(hb), 32'd8);
        check("vblank_clocks", 32'(vb), 32'd6);
    endtask

    task automatic wait_index(input logic sel, input int idx, input string name);
        bit found = 0;
        for (int i = 0; i < 100; i++) begin
            drive_point();
            if (readFrame === 1'b1 && BufSel === sel && FrameRInd === ADDR_W'(idx)) begin
                found = 1;
                break;
            end
        end
        check(name, 32'(found), 32'd1);
    endtask

    initial begin
        reset     = 1'b0;
        CSDisplay = 1'b0;
        HBOut_PD  = 10'd2;
        VBOut_PD  = 10'd1;
        AIPOut_PD = 10'd4;
        AILOut_PD = 10'd3;
        Buf0Empty = 1'b1;
        Buf1Empty = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), 32'd0);
        drive_point();
        reset = 1'b1;

        // Single-frame timing, then underrun on the repeat, then mid-frame disable
        Buf0Empty = 1'b0;
        push_frame(1'b0, 12);
        push_frame(1'b0, 12);
        rel_q.push_back(2'b01);
        CSDisplay = 1'b1;
        wait_fs("first_frame_start");
        measure_frame();
        check("underrun_set", 32'(Underrun), 32'd1);
        check("underrun_bufsel", 32'(BufSel), 32'd0);
        wait_index(1'b0, 5, "reach_index_5");
        CSDisplay = 1'b0;
        wait_rel("disable_release");
        @(negedge clk);
        check("idle_after_disable", out_vec(), 32'h2);
        repeat (20) @(negedge clk);
        check("underrun_sticky", 32'(Underrun), 32'd1);
        drive_point();
        reset = 1'b0;
        @(negedge clk);
        check("underrun_cleared_by_reset", out_vec(), 32'd0);
        drive_point();
        reset = 1'b1;

        // Ping-pong: both buffers full
        Buf0Empty = 1'b0;
        Buf1Empty = 1'b0;
        push_frame(1'b0, 12);
        push_frame(1'b1, 12);
        push_frame(1'b0, 12);
        rel_q.push_back(2'b01);
        rel_q.push_back(2'b10);
        rel_q.push_back(2'b01);
        CSDisplay = 1'b1;
        wait_fs("pp_frame1_start");
        wait_fs("pp_frame2_start");
        check("pp_frame2_bufsel", 32'(BufSel), 32'd1);
        wait_fs("pp_frame3_start");
        check("pp_frame3_bufsel", 32'(BufSel), 32'd0);
        drive_point();
        CSDisplay = 1'b0;
        wait_rel("pp_final_release");
        @(negedge clk);
        check("pp_idle", out_vec(), 32'd0);

        // Illegal configurations
        drive_point();
        Buf0Empty = 1'b1;
        Buf1Empty = 1'b1;
        AIPOut_PD = 10'd0;
        CSDisplay = 1'b1;
        repeat (3) @(negedge clk);
        check("cfg_err_aip0", 32'(CfgErr), 32'd1);
        check("cfg_err_no_read", 32'(readFrame), 32'd0);
        drive_point();
        AIPOut_PD = 10'd257;
        AILOut_PD = 10'd256;
        repeat (3) @(negedge clk);
        check("cfg_err_oversize", 32'(CfgErr), 32'd1);
        drive_point();
        AIPOut_PD = 10'd256;
        repeat (3) @(negedge clk);
        check("cfg_ok_exact_max", 32'(CfgErr), 32'd0);
        drive_point();
        CSDisplay = 1'b0;
        repeat (2) @(negedge clk);
        drive_point();
        AIPOut_PD = 10'd0;
        AILOut_PD = 10'd3;
        Buf0Empty = 1'b0;
        CSDisplay = 1'b1;
        repeat (4) @(negedge clk);
        check("cfg_err_aip0_again", 32'(CfgErr), 32'd1);
        check("cfg_err_stays_idle", 32'(readFrame), 32'd0);
        drive_point();
        push_frame(1'b0, 12);
        rel_q.push_back(2'b01);
        AIPOut_PD = 10'd4;
        wait_fs("cfg_fixed_frame_start");
        check("cfg_err_cleared", 32'(CfgErr), 32'd0);
        drive_point();
        CSDisplay = 1'b0;
        wait_rel("cfg_final_release");
        @(negedge clk);
        check("cfg_idle", out_vec(), 32'd0);

        // Async reset mid-frame while buffer 1 is being read
        drive_point();
        Buf0Empty = 1'b0;
        Buf1Empty = 1'b0;
        push_frame(1'b0, 12);
        push_frame(1'b1, 7);
        rel_q.push_back(2'b01);
        CSDisplay = 1'b1;
        wait_index(1'b1, 7, "reach_buf1_index_7");
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", out_vec(), 32'd0);
        push_frame(1'b0, 12);
        rel_q.push_back(2'b01);
        drive_point();
        reset = 1'b1;
        wait_fs("post_reset_frame_start");
        check("post_reset_bufsel", 32'(BufSel), 32'd0);
        drive_point();
        CSDisplay = 1'b0;
        wait_rel("post_reset_release");
        @(negedge clk);
        check("post_reset_idle", out_vec(), 32'd0);

        repeat (5) @(negedge clk);
        check("pixel_queue_drained", 32'(pix_q.size()), 32'd0);
        check("release_queue_drained", 32'(rel_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Sequences the display DataPath's frame-read side.
- Generates the active-pixel / horizontal-blank / vertical-blank scan from the programmed HB, VB, AIP and AIL counts.
- Drives readFrame and the frame read index, and selects which ping-pong buffer (Buf0/Buf1) feeds each frame based on the DataPath's empty flags.
- Sits between the configuration registers and DataPath; the image loader fills the buffers independently.

Parameters:
- CNT_W, 10, width of timing configuration fields and pixel/line counters.
- ADDR_W, 16, width of frame read index.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- CSDisplay  input  1  display enable; sampled at frame boundaries only.
- HBOut_PD  input  CNT_W  horizontal blank length in clocks.
- VBOut_PD  input  CNT_W  vertical blank length in lines.
- AIPOut_PD  input  CNT_W  active pixels per line.
- AILOut_PD  input  CNT_W  active lines per frame.
- Buf0Empty  input  1  buffer 0 holds no complete image.
- Buf1Empty  input  1  buffer 1 holds no complete image.
- readFrame  output  1  high on every active-pixel clock.
- FrameRInd  output  ADDR_W  frame read index for the current active pixel.
- BufSel  output  1  buffer feeding the current frame (0/1).
- BufRelease  output  2  one-clock pulse; bit n frees buffer n.
- HBlank  output  1  horizontal blank interval.
- VBlank  output  1  vertical blank interval.
- FrameStart  output  1  one-clock pulse on the first active pixel of a frame.
- Underrun  output  1  sticky; set when a frame repeats for lack of a new buffer; cleared only by reset.
- CfgErr  output  1  high while latched config is illegal.

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs 0: FrameRInd=0, BufSel=0, BufRelease=0, Underrun=0, CfgErr=0.
- States: IDLE, WAIT_BUF, ACTIVE, HBLK, VBLK.
- IDLE:
  - On CSDisplay=1, latch HB, VB, AIP, AIL into shadow registers.
  - If AIP=0 or AIL=0, or AIP*AIL > 2^ADDR_W (full-width product), set CfgErr=1 and stay IDLE, re-latching every clock.
  - Otherwise clear CfgErr and go to WAIT_BUF.
- WAIT_BUF: wait until either buffer is non-empty.
  - Buf0 has priority when both are non-empty.
  - Set BufSel to the chosen buffer, reset counters, go to ACTIVE next clock.
  - If CSDisplay drops, return to IDLE.
- ACTIVE:
  - readFrame=1. FrameRInd = current index; index increments by 1 per active pixel.
  - Pixel counter runs 0..AIP-1. FrameStart=1 on pixel 0 of line 0.
  - After pixel AIP-1: go to HBLK if HB>0; else start the next line directly.
- HBLK:
  - HBlank=1 for exactly HB clocks, then advance the line.
  - After line AIL-1 completes: go to VBLK if VB>0; else go to the frame boundary.
- VBLK:
  - VBlank=1 for VB lines of (AIP+HB) clocks each. readFrame=0.
  - HBlank also pulses in the HB portion of each blank line.
- Frame boundary, evaluated on the last VBLK clock, or the last line's end when VB=0:
  - CSDisplay=0: pulse BufRelease[BufSel], go to IDLE.
  - Other buffer non-empty: pulse BufRelease[BufSel], toggle BufSel, re-latch config, restart ACTIVE with FrameRInd=0.
  - Other buffer empty: keep BufSel, set Underrun, restart ACTIVE. No release pulse.
  - If newly latched config is illegal: release the current buffer, set CfgErr, go to IDLE.
- Config inputs changing mid-frame have no effect until the next boundary.
- CSDisplay toggling mid-frame is ignored; the frame always completes.
- Frame latency: FrameRInd/readFrame valid the clock after leaving WAIT_BUF. FrameRInd is registered, not combinational.
- Reset mid-frame: immediate return to reset values. No release pulse issued.

Test Plan:
- Single frame timing. AIP=4, HB=2, AIL=3, VB=1, Buf0Empty=0, Buf1Empty=1, CSDisplay=1 → after WAIT_BUF:
  - readFrame high 4 clocks per line, FrameRInd 0..11.
  - HBlank 2 clocks per line; VBlank 6 clocks.
  - Frame period 24 clocks; FrameStart once per frame.
- Ping-pong swap. Same config with both buffers non-empty:
  - Frame 1 BufSel=0.
  - At boundary, BufRelease=2'b01 for 1 clock, BufSel=1.
  - Next boundary: BufRelease=2'b10, BufSel=0.
- Underrun. Buf1Empty stays 1 throughout → second frame repeats BufSel=0, Underrun=1 and stays set, BufRelease never pulses.
- Illegal config. AIP=0 with CSDisplay=1 → CfgErr=1, state IDLE, readFrame=0. Setting AIP=4 → CfgErr clears, enters WAIT_BUF.
- Mid-frame disable. Drop CSDisplay at FrameRInd=5 → frame completes through VBLK, BufRelease[BufSel] pulses, then idle with all outputs 0.
- Async reset. Assert reset low at FrameRInd=7, between clock edges → outputs 0 immediately. After release with CSDisplay=1 → new frame starts with FrameRInd=0, BufSel chosen afresh.
